// File: rtl/phase_center_pkg.sv
// Shared constants and types for the phase1 center RAM load controller.
// Strobe positions, field-slice helpers and the sequencer state encoding.
package phase_center_pkg;

   localparam int WORD_W      = 32;
   localparam int LOAD_BIT    = 31;
   localparam int CLEAR_BIT   = 30;
   localparam int MAX_FIELD_W = 30;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

   function automatic int data_lsb();
      return 0;
   endfunction

   function automatic int addr_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int field_msb(input int addr_w, input int data_w);
      return addr_w + data_w - 1;
   endfunction

endpackage

// File: rtl/sw_reg_edge_det.sv
// Registers a software register word and flags per-bit rising edges.
// Reset value is a parameter so levels held across reset can be masked.
module sw_reg_edge_det #(
   parameter int           W       = 32,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise
);

   logic [W-1:0] in_q;
   logic [W-1:0] in_d;
   logic [W-1:0] prev_q;
   logic [W-1:0] prev_d;

   always_comb begin
      in_d   = d;
      prev_d = in_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q   <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         in_q   <= in_d;
         prev_q <= prev_d;
      end
   end

   assign q    = in_q;
   assign rise = in_q & ~prev_q;

endmodule

// File: rtl/phase_center_load_ctrl.sv
// Turns load_centers register strobes into single-cycle center RAM writes,
// with a clear-all sweep and busy/accepted/dropped status for readback.
module phase_center_load_ctrl
   import phase_center_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       user_data_out,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              busy,
   output logic [CNT_W-1:0]  load_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic [ADDR_W-1:0] last_addr
);

   localparam int A_LSB = addr_lsb(DATA_W);
   localparam int D_LSB = data_lsb();

   if (field_msb(ADDR_W, DATA_W) >= MAX_FIELD_W) begin : g_bad_fields
      $error("ADDR_W + DATA_W must not exceed 30");
   end

   logic [WORD_W-1:0] in_word;
   logic [WORD_W-1:0] rise;
   logic              ld_e;
   logic              clr_e;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_data;
   logic              unused_bits;

   sw_reg_edge_det #(
      .W       (WORD_W),
      .RST_VAL ({WORD_W{1'b1}})
   ) u_edge (
      .clk  (user_clk),
      .rst  (user_rst),
      .d    (user_data_out),
      .q    (in_word),
      .rise (rise)
   );

   assign ld_e        = rise[LOAD_BIT];
   assign clr_e       = rise[CLEAR_BIT];
   assign f_addr      = in_word[A_LSB +: ADDR_W];
   assign f_data      = in_word[D_LSB +: DATA_W];
   assign unused_bits = ^{rise[CLEAR_BIT-1:0], in_word};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;
   logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic [DATA_W-1:0] cap_data_q, cap_data_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic              drop_inc;

   // RAM port signals are registered from the state, one cycle behind it
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      cap_addr_d  = cap_addr_q;
      cap_data_d  = cap_data_q;
      we_d        = 1'b0;
      busy_d      = 1'b0;
      addr_d      = addr_q;
      din_d       = din_q;
      load_cnt_d  = load_cnt_q;
      last_addr_d = last_addr_q;
      drop_inc    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (clr_e) begin
               state_d  = ST_CLEAR;
               sweep_d  = '0;
               drop_inc = ld_e;
            end else if (ld_e) begin
               state_d    = ST_WRITE;
               cap_addr_d = f_addr;
               cap_data_d = f_data;
            end
         end
         ST_WRITE: begin
            we_d        = 1'b1;
            busy_d      = 1'b1;
            addr_d      = cap_addr_q;
            din_d       = cap_data_q;
            load_cnt_d  = load_cnt_q + CNT_W'(1);
            last_addr_d = cap_addr_q;
            drop_inc    = ld_e | clr_e;
            state_d     = ST_IDLE;
         end
         ST_CLEAR: begin
            we_d     = 1'b1;
            busy_d   = 1'b1;
            addr_d   = sweep_q;
            din_d    = '0;
            sweep_d  = sweep_q + ADDR_W'(1);
            drop_inc = ld_e | clr_e;
            if (&sweep_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      drop_cnt_d = drop_cnt_q;
      if (drop_inc && !(&drop_cnt_q)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q     <= ST_IDLE;
         sweep_q     <= '0;
         cap_addr_q  <= '0;
         cap_data_q  <= '0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         load_cnt_q  <= '0;
         drop_cnt_q  <= '0;
         last_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         cap_addr_q  <= cap_addr_d;
         cap_data_q  <= cap_data_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         load_cnt_q  <= load_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         last_addr_q <= last_addr_d;
      end
   end

   assign ram_we     = we_q;
   assign ram_addr   = addr_q;
   assign ram_din    = din_q;
   assign busy       = busy_q;
   assign load_count = load_cnt_q;
   assign drop_count = drop_cnt_q;
   assign last_addr  = last_addr_q;

endmodule

// File: tb/tb_phase_center_load_ctrl.sv
// Self-checking bench: timed write schedule model driven by strobe history.
// Random and directed scenarios compared against the model's writes/counters.
module tb_phase_center_load_ctrl;

   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   din_w = '0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          busy;
   logic [CW-1:0] load_count;
   logic [CW-1:0] drop_count;
   logic [AW-1:0] last_addr;

   phase_center_load_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .user_clk      (clk),
      .user_rst      (rst),
      .user_data_out (din_w),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_din       (ram_din),
      .busy          (busy),
      .load_count    (load_count),
      .drop_count    (drop_count),
      .last_addr     (last_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   // keyed by clock edge after which ram_we is high
   wr_t exp_wr[int];
   wr_t obs_wr[int];
   int  busy_err = 0;

   always @(negedge clk) begin
      if (ram_we === 1'b1) obs_wr[cyc] = '{ram_addr, ram_din};
      if (busy !== ram_we) busy_err++;
   end

   logic [31:0]   m_prev = '1;
   logic [31:0]   m_pend_word = '0;
   logic          m_pend_ld = 1'b0;
   logic          m_pend_cl = 1'b0;
   int            m_free = 0;
   logic [CW-1:0] m_load = '0;
   logic [CW-1:0] m_drop = '0;
   logic [AW-1:0] m_last = '0;

   task automatic m_bump_drop();
      if (m_drop != '1) m_drop = m_drop + 1'b1;
   endtask

   // a strobe edge is decided at edge d; accepted work lands from d+1
   task automatic m_decide(input int d);
      if (d >= m_free) begin
         if (m_pend_cl) begin
            for (int i = 0; i < DEPTH; i++)
               exp_wr[d + 1 + i] = '{AW'(i), DW'(0)};
            m_free = d + 1 + DEPTH;
            if (m_pend_ld) m_bump_drop();
         end else begin
            exp_wr[d + 1] = '{m_pend_word[DW +: AW], m_pend_word[DW-1:0]};
            m_load = m_load + 1'b1;
            m_last = m_pend_word[DW +: AW];
            m_free = d + 2;
         end
      end else begin
         m_bump_drop();
      end
   endtask

   task automatic step(input logic [31:0] w, input logic r);
      int k;
      int doomed[$];
      k = cyc + 1;
      if (r) begin
         foreach (exp_wr[e]) if (e >= k) doomed.push_back(e);
         foreach (doomed[i]) exp_wr.delete(doomed[i]);
         m_prev    = '1;
         m_pend_ld = 1'b0;
         m_pend_cl = 1'b0;
         m_free    = 0;
         m_load    = '0;
         m_drop    = '0;
         m_last    = '0;
      end else begin
         if (m_pend_ld || m_pend_cl) m_decide(k);
         m_pend_ld   = w[31] & ~m_prev[31];
         m_pend_cl   = w[30] & ~m_prev[30];
         m_pend_word = w;
         m_prev      = w;
      end
      din_w = w;
      rst   = r;
      @(negedge clk);
   endtask

   function automatic int write_errs();
      int n = 0;
      foreach (exp_wr[e])
         if (!obs_wr.exists(e) || obs_wr[e] !== exp_wr[e]) n++;
      foreach (obs_wr[e])
         if (!exp_wr.exists(e)) n++;
      return n;
   endfunction

   task automatic fresh_start();
      step(32'h0, 1'b1);
      step(32'h0, 1'b1);
      step(32'h0, 1'b0);
      step(32'h0, 1'b0);
      exp_wr.delete();
      obs_wr.delete();
      busy_err = 0;
   endtask

   task automatic test_reset();
      logic [31:0] w;
      w = $urandom;
      step(w, 1'b1);
      step(w, 1'b1);
      step(w, 1'b1);
      total++;
      if (ram_we !== 1'b0) begin
         bad++; $display("FAIL rst_we got=%0b want=0", ram_we);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL rst_busy got=%0b want=0", busy);
      end
      total++;
      if (ram_addr !== '0 || ram_din !== '0) begin
         bad++; $display("FAIL rst_port got=%h/%h want=0/0", ram_addr, ram_din);
      end
      total++;
      if (load_count !== '0 || drop_count !== '0) begin
         bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", load_count, drop_count);
      end
      total++;
      if (last_addr !== '0) begin
         bad++; $display("FAIL rst_last got=%0d want=0", last_addr);
      end
   endtask

   task automatic test_single_load();
      int k0;
      int n;
      fresh_start();
      k0 = cyc + 1;
      step(32'h8005_1234, 1'b0);
      repeat (6) step(32'h8005_1234, 1'b0);
      n = write_errs();
      total++;
      if (n !== 0) begin
         bad++; $display("FAIL load_writes got=%0d errs want=0", n);
      end
      total++;
      if (obs_wr.num() !== 1 || !obs_wr.exists(k0 + 2)) begin
         bad++; $display("FAIL load_latency got=%0d writes want=1 at edge %0d", obs_wr.num(), k0 + 2);
      end
      total++;
      if (ram_addr !== 10'd5 || ram_din !== 16'h1234) begin
         bad++; $display("FAIL load_port got=%0d/%h want=5/1234", ram_addr, ram_din);
      end
      total++;
      if (load_count !== 16'd1 || last_addr !== 10'd5) begin
         bad++; $display("FAIL load_status got=%0d/%0d want=1/5", load_count, last_addr);
      end
   endtask

   task automatic test_held_through_reset();
      exp_wr.delete();
      obs_wr.delete();
      repeat (3) step(32'h8000_0001, 1'b1);
      repeat (10) step(32'h8000_0001, 1'b0);
      total++;
      if (obs_wr.num() !== 0) begin
         bad++; $display("FAIL held_writes got=%0d want=0", obs_wr.num());
      end
      total++;
      if (load_count !== '0 || drop_count !== '0) begin
         bad++; $display("FAIL held_cnt got=%0d/%0d want=0/0", load_count, drop_count);
      end
   endtask

   task automatic test_clear_sweep();
      int k0;
      int n;
      fresh_start();
      k0 = cyc + 1;
      step(32'h4000_0000, 1'b0);
      repeat (DEPTH + 6) step(32'h4000_0000, 1'b0);
      n = write_errs();
      total++;
      if (n !== 0) begin
         bad++; $display("FAIL sweep_writes got=%0d errs want=0", n);
      end
      total++;
      if (obs_wr.num() !== DEPTH || !obs_wr.exists(k0 + 2) || !obs_wr.exists(k0 + 1 + DEPTH)) begin
         bad++; $display("FAIL sweep_span got=%0d writes want=%0d from edge %0d", obs_wr.num(), DEPTH, k0 + 2);
      end
      total++;
      if (busy_err !== 0 || busy !== 1'b0) begin
         bad++; $display("FAIL sweep_busy got=%0d errs busy=%0b want=0/0", busy_err, busy);
      end
      total++;
      if (ram_addr !== 10'd1023 || ram_din !== '0) begin
         bad++; $display("FAIL sweep_hold got=%0d/%h want=1023/0", ram_addr, ram_din);
      end
   endtask

   task automatic test_drop_during_clear();
      int n;
      fresh_start();
      step(32'h4000_0000, 1'b0);
      repeat (20) step(32'h4000_0000, 1'b0);
      repeat (3) begin
         step(32'hC000_0000, 1'b0);
         step(32'h4000_0000, 1'b0);
      end
      repeat (DEPTH) step(32'h4000_0000, 1'b0);
      n = write_errs();
      total++;
      if (n !== 0 || obs_wr.num() !== DEPTH) begin
         bad++; $display("FAIL dropclr_writes got=%0d errs %0d writes want=0/%0d", n, obs_wr.num(), DEPTH);
      end
      total++;
      if (drop_count !== 16'd3 || drop_count !== m_drop) begin
         bad++; $display("FAIL dropclr_drop got=%0d want=3", drop_count);
      end
      total++;
      if (load_count !== '0) begin
         bad++; $display("FAIL dropclr_load got=%0d want=0", load_count);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      fresh_start();
      step(32'hC000_0000, 1'b0);
      repeat (DEPTH + 6) step(32'hC000_0000, 1'b0);
      n = write_errs();
      total++;
      if (n !== 0 || obs_wr.num() !== DEPTH) begin
         bad++; $display("FAIL simul_writes got=%0d errs %0d writes want=0/%0d", n, obs_wr.num(), DEPTH);
      end
      total++;
      if (drop_count !== 16'd1 || load_count !== '0) begin
         bad++; $display("FAIL simul_cnt got=%0d/%0d want=1/0", drop_count, load_count);
      end
   endtask

   task automatic test_reset_mid_sweep();
      bit found;
      int n;
      logic [31:0] w;
      fresh_start();
      found = 1'b0;
      step(32'h4000_0000, 1'b0);
      for (int i = 0; i < DEPTH + 20 && !found; i++) begin
         step(32'h4000_0000, 1'b0);
         if (ram_we === 1'b1 && ram_addr === 10'd300) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL midrst_reach got=timeout want=addr 300");
      end
      step(32'h4000_0000, 1'b1);
      total++;
      if (ram_we !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL midrst_abort got=%0b/%0b want=0/0", ram_we, busy);
      end
      total++;
      if (load_count !== '0 || drop_count !== '0 || ram_addr !== '0) begin
         bad++; $display("FAIL midrst_cnt got=%0d/%0d/%0d want=0/0/0", load_count, drop_count, ram_addr);
      end
      step(32'h0, 1'b0);
      step(32'h0, 1'b0);
      w = 32'h8007_0000 | 32'($urandom_range(0, 16'hFFFF));
      repeat (8) step(w, 1'b0);
      n = write_errs();
      total++;
      if (n !== 0) begin
         bad++; $display("FAIL midrst_writes got=%0d errs want=0", n);
      end
      total++;
      if (load_count !== 16'd1 || last_addr !== 10'd7) begin
         bad++; $display("FAIL midrst_load got=%0d/%0d want=1/7", load_count, last_addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic ld;
      logic cl;
      int n;
      fresh_start();
      ld = 1'b0;
      cl = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) ld = ~ld;
         cl = ($urandom_range(0, 299) == 0) ? ~cl : cl;
         w = {ld, cl, 30'($urandom)};
         step(w, 1'b0);
      end
      repeat (DEPTH + 8) step(32'h0, 1'b0);
      n = write_errs();
      total++;
      if (n !== 0) begin
         bad++; $display("FAIL rand_writes got=%0d errs want=0", n);
      end
      total++;
      if (load_count !== m_load || last_addr !== m_last) begin
         bad++; $display("FAIL rand_load got=%0d/%0d want=%0d/%0d", load_count, last_addr, m_load, m_last);
      end
      total++;
      if (drop_count !== m_drop) begin
         bad++; $display("FAIL rand_drop got=%0d want=%0d", drop_count, m_drop);
      end
      total++;
      if (busy_err !== 0) begin
         bad++; $display("FAIL rand_busy got=%0d errs want=0", busy_err);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_load();
      test_held_through_reset();
      test_clear_sweep();
      test_drop_during_clear();
      test_simultaneous();
      test_reset_mid_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
